score_blit_scheduler: RTL and testbench

- Per-frame sequencer for the score area of the HUD: schedules the "HI" label, high-score digits and current distance digits onto the single shared sprite blitter request port.
- Sits between the distance meter (digits/paint source) and the sprite blitter. Owns the high-score register.
- Snapshots its inputs once per frame so digit or flash changes cannot tear mid-frame.

---
 rtl/score_blit_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_score_blit_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_blit_scheduler.sv
// score_blit_scheduler: per-frame HUD score sequencer ("HI", hi, cur).
// digits/hi pack digit 0 (MSD) in the top nibble.
module score_blit_scheduler #(
  parameter int MAX_DISTANCE_UNITS = 5,
  parameter int DEST_WIDTH = 11,
  parameter int X = 1148,
  parameter int Y = 20,
  parameter int HI_X = X - 8 * DEST_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            frame_start,
  input  logic [4*MAX_DISTANCE_UNITS-1:0] digits,
  input  logic                            paint,
  input  logic                            game_over,
  input  logic                            clear_hi,
  output logic                            blit_valid,
  input  logic                            blit_ready,
  output logic [10:0]                     blit_x,
  output logic [9:0]                      blit_y,
  output logic [3:0]                      blit_sprite,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            overrun
);

  localparam int DW = 4 * MAX_DISTANCE_UNITS;
  localparam logic [2:0] LAST = 3'(MAX_DISTANCE_UNITS - 1);
  localparam logic [3:0] SPR_H = 4'd10;
  localparam logic [3:0] SPR_I = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    LABEL_H,
    LABEL_I,
    HI_DIGIT,
    CUR_DIGIT,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [DW-1:0]   cur_q, cur_d;
  logic [DW-1:0]   hi_s_q, hi_s_d;
  logic            paint_s_q, paint_s_d;
  logic [DW-1:0]   hi_q;

  logic            valid_q, valid_d;
  logic [10:0]     x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic [3:0]      spr_q, spr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;
  logic            xfer;

  function automatic logic [3:0] dig_at(
    input logic [DW-1:0] v,
    input logic [2:0]    i
  );
    logic [DW-1:0] s;
    s = v << {i, 2'b00};
    return s[DW-1 -: 4];
  endfunction

  function automatic logic [10:0] pitch(
    input logic [2:0] i
  );
    return 11'(DEST_WIDTH) * {8'd0, i};
  endfunction

  assign xfer = valid_q && blit_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_d     = cur_q;
    hi_s_d    = hi_s_q;
    paint_s_d = paint_s_q;
    ovr_d     = frame_start && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          cur_d     = digits;
          hi_s_d    = hi_q;
          paint_s_d = paint;
          idx_d     = 3'd0;
          if (hi_q != '0)
            state_d = LABEL_H;
          else if (paint)
            state_d = CUR_DIGIT;
          else
            state_d = DONE;
        end
      end
      LABEL_H: begin
        if (xfer) state_d = LABEL_I;
      end
      LABEL_I: begin
        if (xfer) begin
          state_d = HI_DIGIT;
          idx_d   = 3'd0;
        end
      end
      HI_DIGIT: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            idx_d   = 3'd0;
            state_d = paint_s_q ? CUR_DIGIT : DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      CUR_DIGIT: begin
        if (xfer) begin
          if (idx_q == LAST) begin
            idx_d   = 3'd0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are decoded from the next state so they are registered.
  always_comb begin
    valid_d = 1'b0;
    x_d     = '0;
    y_d     = '0;
    spr_d   = '0;
    unique case (state_d)
      LABEL_H: begin
        valid_d = 1'b1;
        x_d     = 11'(HI_X);
        spr_d   = SPR_H;
      end
      LABEL_I: begin
        valid_d = 1'b1;
        x_d     = 11'(HI_X + DEST_WIDTH);
        spr_d   = SPR_I;
      end
      HI_DIGIT: begin
        valid_d = 1'b1;
        x_d     = 11'(HI_X + 2 * DEST_WIDTH)
                + pitch(idx_d);
        spr_d   = dig_at(hi_s_d, idx_d);
      end
      CUR_DIGIT: begin
        valid_d = 1'b1;
        x_d     = 11'(X) + pitch(idx_d);
        spr_d   = dig_at(cur_d, idx_d);
      end
      default: ;
    endcase
    if (valid_d) y_d = 10'(Y);
    busy_d = valid_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cur_q     <= '0;
      hi_s_q    <= '0;
      paint_s_q <= 1'b0;
      valid_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      spr_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cur_q     <= cur_d;
      hi_s_q    <= hi_s_d;
      paint_s_q <= paint_s_d;
      valid_q   <= valid_d;
      x_q       <= x_d;
      y_q       <= y_d;
      spr_q     <= spr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  // MSD-first nibble packing makes a plain compare the BCD compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hi_q <= '0;
    else if (clear_hi)
      hi_q <= '0;
    else if (game_over && (digits > hi_q))
      hi_q <= digits;
  end

  assign blit_valid  = valid_q;
  assign blit_x      = x_q;
  assign blit_y      = y_q;
  assign blit_sprite = spr_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_score_blit_scheduler.sv
// tb_score_blit_scheduler: directed steps with a glyph scoreboard.
// Expected glyphs are queued at frame start, checked on every valid cycle.
module tb_score_blit_scheduler;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [19:0] digits;
  logic        paint;
  logic        game_over;
  logic        clear_hi;
  logic        blit_valid;
  logic        blit_ready;
  logic [10:0] blit_x;
  logic [9:0]  blit_y;
  logic [3:0]  blit_sprite;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  int          errors = 0;
  int          checks = 0;
  logic [19:0] hi_m;
  logic [24:0] sb[$];

  score_blit_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .digits     (digits),
    .paint      (paint),
    .game_over  (game_over),
    .clear_hi   (clear_hi),
    .blit_valid (blit_valid),
    .blit_ready (blit_ready),
    .blit_x     (blit_x),
    .blit_y     (blit_y),
    .blit_sprite(blit_sprite),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] dig(
    input logic [19:0] v,
    input int          i
  );
    return v[19 - 4 * i -: 4];
  endfunction

  function automatic logic gt(
    input logic [19:0] a,
    input logic [19:0] b
  );
    for (int i = 0; i < 5; i++) begin
      if (dig(a, i) > dig(b, i)) return 1'b1;
      if (dig(a, i) < dig(b, i)) return 1'b0;
    end
    return 1'b0;
  endfunction

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [3:0]  s,
    input logic [10:0] x
  );
    sb.push_back({s, x, 10'd20});
  endtask

  task automatic start_frame(
    input logic [19:0] d,
    input logic        p
  );
    digits = d;
    paint  = p;
    if (hi_m != 20'd0) begin
      push(4'd10, 11'd1060);
      push(4'd11, 11'd1071);
      for (int i = 0; i < 5; i++)
        push(dig(hi_m, i), 11'(1082 + 11 * i));
    end
    if (p)
      for (int i = 0; i < 5; i++)
        push(dig(d, i), 11'(1148 + 11 * i));
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    digits = 20'hEEEEE;
    paint  = ~p;
  endtask

  task automatic finish_frame(
    input int mode,
    input int exp
  );
    int k;
    k = 0;
    while (!frame_done && k < exp + 20) begin
      blit_ready = (mode == 0) || (k % 3 == 2);
      step();
      if (!frame_done) chk("busy_run", int'(busy), 1);
      k++;
    end
    chk("done_cycles", k, exp);
    chk("sb_empty", sb.size(), 0);
    chk("busy_at_done", int'(busy), 0);
    blit_ready = 1'b1;
    step();
    chk("done_pulse", int'(frame_done), 0);
  endtask

  task automatic game(
    input logic [19:0] d,
    input logic        clr
  );
    digits    = d;
    game_over = 1'b1;
    clear_hi  = clr;
    step();
    game_over = 1'b0;
    clear_hi  = 1'b0;
    if (clr) hi_m = 20'd0;
    else if (gt(d, hi_m)) hi_m = d;
  endtask

  always @(negedge clk) begin
    if (rst_n && blit_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected obs=%0d/%0d exp=none",
               blit_sprite, blit_x);
      end
      if (sb.size() != 0) begin
        checks++;
        assert ({blit_sprite, blit_x, blit_y} === sb[0])
        else begin
          errors++;
          $error("FAIL glyph obs=%0d@%0d,%0d exp=%0d@%0d,%0d",
                 blit_sprite, blit_x, blit_y,
                 sb[0][24:21], sb[0][20:10], sb[0][9:0]);
        end
        if (blit_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    digits      = 20'd0;
    paint       = 1'b1;
    game_over   = 1'b0;
    clear_hi    = 1'b0;
    blit_ready  = 1'b1;
    hi_m        = 20'd0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", int'(blit_valid), 0);
    chk("rst_x", int'(blit_x), 0);
    chk("rst_y", int'(blit_y), 0);
    chk("rst_sprite", int'(blit_sprite), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);

    start_frame(20'h00123, 1'b1);
    chk("a_busy", int'(busy), 1);
    finish_frame(0, 5);

    game(20'h00456, 1'b0);
    start_frame(20'h00123, 1'b1);
    finish_frame(0, 12);

    game(20'h00455, 1'b0);
    start_frame(20'h00123, 1'b0);
    finish_frame(0, 7);
    game(20'h00460, 1'b0);
    start_frame(20'h00123, 1'b0);
    finish_frame(0, 7);

    start_frame(20'h09C3F, 1'b1);
    finish_frame(1, 36);

    start_frame(20'h00789, 1'b1);
    step();
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("ovr_pulse", int'(overrun), 1);
    step();
    chk("ovr_clear", int'(overrun), 0);
    finish_frame(0, 8);

    start_frame(20'h00321, 1'b1);
    repeat (9) step();
    chk("pre_rst_valid", int'(blit_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(blit_valid), 0);
    chk("arst_busy", int'(busy), 0);
    sb.delete();
    hi_m = 20'd0;
    step();
    chk("arst_done", int'(frame_done), 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_done", int'(frame_done), 0);
    start_frame(20'h00123, 1'b1);
    finish_frame(0, 5);

    start_frame(20'h00123, 1'b0);
    chk("empty_valid", int'(blit_valid), 0);
    finish_frame(0, 0);

    game(20'h00700, 1'b0);
    game(20'h99999, 1'b1);
    start_frame(20'h00123, 1'b0);
    finish_frame(0, 0);

    step();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
